// File: rtl/pwm_drive_pkg.sv
// pwm_drive_pkg: shared state encoding, default constants and helpers for the H-bridge PWM sequencer.
package pwm_drive_pkg;
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_RAMP_DOWN, S_COAST, S_FAULT} state_e;
  localparam int unsigned PERIOD_DEF     = 500;
  localparam int unsigned DUTY_MAX_DEF   = 480;
  localparam int unsigned RAMP_STEP_DEF  = 5;
  localparam int unsigned GAP_FRAMES_DEF = 2;
  function automatic logic [31:0] min32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction
endpackage

// File: rtl/frame_timer.sv
// frame_timer: PWM-period counter; held at 0 while not running, frame_tick_o marks the wrap cycle.
module frame_timer #(
  parameter int unsigned PERIOD = 500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  output logic frame_tick_o
);
  logic [31:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= (!run_i || cnt_q == PERIOD) ? '0 : cnt_q + 32'd1;
  assign frame_tick_o = run_i && cnt_q == PERIOD;
endmodule

// File: rtl/pwm_drive_sequencer.sv
// pwm_drive_sequencer: slew-limited speed/direction sequencer for one H-bridge channel.
// Duty/direction only change on the edge after a frame boundary so they track the PWM counter wrap.
module pwm_drive_sequencer
  import pwm_drive_pkg::*;
#(
  parameter int unsigned PERIOD     = PERIOD_DEF,
  parameter int unsigned DUTY_MAX   = DUTY_MAX_DEF,
  parameter int unsigned RAMP_STEP  = RAMP_STEP_DEF,
  parameter int unsigned GAP_FRAMES = GAP_FRAMES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_duty,
  input  logic        cmd_dir,
  input  logic        fault,
  input  logic        fault_clr,
  output logic        pwm_enable,
  output logic [31:0] duty_fwd,
  output logic [31:0] duty_rev,
  output logic [31:0] cur_duty,
  output logic        cur_dir,
  output logic        fault_latched,
  output logic        busy
);
  state_e      state_q, state_d;
  logic [31:0] target_q, target_d, cur_q, cur_d, gap_q, gap_d;
  logic [31:0] duty_fwd_q, duty_rev_q, diff, stepped;
  logic        tgt_dir_q, tgt_dir_d, cur_dir_q, cur_dir_d, latched_q, latched_d;
  logic        en_q, busy_q, tick, accept, up;

  frame_timer #(.PERIOD(PERIOD)) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .run_i       (en_q),
    .frame_tick_o(tick)
  );

  assign cmd_ready = (state_q == S_IDLE || state_q == S_RUN) && !fault && !latched_q;
  assign accept    = cmd_valid && cmd_ready;
  assign up        = target_q > cur_q;
  assign diff      = up ? target_q - cur_q : cur_q - target_q;
  assign stepped   = up ? cur_q + min32(diff, RAMP_STEP) : cur_q - min32(diff, RAMP_STEP);

  always_comb begin
    state_d   = state_q;
    target_d  = accept ? min32(cmd_duty, DUTY_MAX) : target_q;
    tgt_dir_d = accept ? cmd_dir : tgt_dir_q;
    cur_d     = cur_q;
    cur_dir_d = cur_dir_q;
    gap_d     = gap_q;
    latched_d = latched_q;
    case (state_q)
      S_IDLE: if (accept && target_d != 0) begin
        state_d   = S_RUN;
        cur_dir_d = cmd_dir;
      end
      S_RUN: if (tick) begin
        if (tgt_dir_q != cur_dir_q) begin
          state_d = (cur_q != 0) ? S_RAMP_DOWN : S_COAST;
          gap_d   = GAP_FRAMES;
        end else if (cur_q == 0 && target_q == 0) state_d = S_IDLE;
        else cur_d = stepped;
      end
      S_RAMP_DOWN: if (tick) begin
        cur_d = cur_q - min32(RAMP_STEP, cur_q);
        if (cur_d == 0) begin
          state_d = S_COAST;
          gap_d   = GAP_FRAMES;
        end
      end
      S_COAST: if (tick) begin
        gap_d = (gap_q == 0) ? '0 : gap_q - 32'd1;
        if (gap_d == 0) begin
          state_d   = S_RUN;
          cur_dir_d = tgt_dir_q;
        end
      end
      S_FAULT: if (fault_clr && !fault) begin
        state_d   = S_IDLE;
        latched_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    // Fault overrides everything decided above, including a same-cycle accept.
    if (fault) begin
      state_d   = S_FAULT;
      cur_d     = '0;
      target_d  = '0;
      latched_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= S_IDLE;
      target_q   <= '0;
      tgt_dir_q  <= 1'b0;
      cur_q      <= '0;
      cur_dir_q  <= 1'b0;
      gap_q      <= '0;
      latched_q  <= 1'b0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      duty_fwd_q <= '0;
      duty_rev_q <= '0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      tgt_dir_q  <= tgt_dir_d;
      cur_q      <= cur_d;
      cur_dir_q  <= cur_dir_d;
      gap_q      <= gap_d;
      latched_q  <= latched_d;
      en_q       <= state_d inside {S_RUN, S_RAMP_DOWN, S_COAST};
      busy_q     <= state_d inside {S_RAMP_DOWN, S_COAST};
      duty_fwd_q <= cur_dir_d ? '0 : cur_d;
      duty_rev_q <= cur_dir_d ? cur_d : '0;
    end

  assign pwm_enable    = en_q;
  assign duty_fwd      = duty_fwd_q;
  assign duty_rev      = duty_rev_q;
  assign cur_duty      = cur_q;
  assign cur_dir       = cur_dir_q;
  assign fault_latched = latched_q;
  assign busy          = busy_q;
endmodule

// File: doc/pwm_drive_sequencer.md
# pwm_drive_sequencer

Sequencer for one H-bridge motor channel, driving two dead-time PWM counter instances (forward leg, reverse leg). It accepts speed/direction commands over a valid/ready handshake and slew-limits duty changes. Reversals go through a forced ramp-to-zero and coast gap. A fault input shuts the bridge down immediately. Sits between the command decoder and the PWM counter pair, and owns their `enable` and `duty` inputs.

## Interface
- `PERIOD`, 500: PWM period value; frame = PERIOD+1 clk cycles, matching the PWM counter wrap.
- `DUTY_MAX`, 480: duty clamp; must be < PERIOD.
- `RAMP_STEP`, 5: maximum |duty change| per frame.
- `GAP_FRAMES`, 2: number of coast frames (both duties 0) between direction changes.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when valid && ready.
- `cmd_duty`  in  32  requested duty magnitude.
- `cmd_dir`  in  1  0 = forward, 1 = reverse.
- `fault`  in  1  level; bridge fault (overcurrent/driver).
- `fault_clr`  in  1  pulse; clears latched fault.
- `pwm_enable`  out  1  to both PWM counters.
- `duty_fwd`  out  32  to the forward PWM counter.
- `duty_rev`  out  32  to the reverse PWM counter.
- `cur_duty`  out  32  applied duty magnitude.
- `cur_dir`  out  1  applied direction.
- `fault_latched`  out  1  sticky fault flag.
- `busy`  out  1  high in RAMP_DOWN or COAST.

## Operation
- States: IDLE, RUN, RAMP_DOWN, COAST, FAULT.
- Reset: state IDLE. All outputs are 0: `pwm_enable`, both duties, `cur_duty`, `cur_dir`, `fault_latched`, `busy`, and the internal target.
- `cmd_ready` = (state==IDLE || state==RUN) && !fault && !fault_latched.
- On accept:
  - target = min(cmd_duty, DUTY_MAX); tgt_dir = cmd_dir.
  - The newest accepted command in RUN overrides the previous target.
- IDLE:
  - Accept with target>0 → RUN: `pwm_enable`=1 and frame counter=0 on the next cycle. The PWM counters start from 0 on the same edge, so both stay aligned.
  - If cur_dir≠tgt_dir, the direction is adopted directly, because cur_duty is 0.
  - Accept with target 0 → stay IDLE.
- Frame boundary = frame counter == PERIOD. The counter is held at 0 outside RUN/RAMP_DOWN/COAST.
- RUN, at each boundary:
  - If tgt_dir≠cur_dir and cur_duty>0 → RAMP_DOWN.
  - Else if tgt_dir≠cur_dir and cur_duty==0 → COAST.
  - Else cur_duty steps toward target by min(RAMP_STEP, |target−cur_duty|).
  - If cur_duty==0 and target==0 → IDLE.
- RAMP_DOWN: each boundary, cur_duty −= min(RAMP_STEP, cur_duty). On reaching 0 → COAST with gap counter = GAP_FRAMES.
- COAST: both duties 0, enable held high. The gap counter decrements at each boundary; at 0 → cur_dir = tgt_dir, then RUN.
- Duty routing: cur_dir=0 → duty_fwd=cur_duty, duty_rev=0; cur_dir=1 → the reverse. Never both nonzero.
- FAULT, entered from any state when `fault`=1 is sampled (highest priority):
  - Next cycle: `pwm_enable`=0, both duties 0, cur_duty 0, target 0, `fault_latched`=1.
  - Exit to IDLE on `fault_clr`=1 while `fault`=0. `fault_clr` while `fault`=1 is ignored.
- Arithmetic is 32-bit unsigned; step and subtraction must never underflow.

## Timing
- Registered outputs; all duty/dir changes occur only on the cycle after a frame boundary, i.e. coincident with the PWM counter wrap.
- Command accept → target latched next cycle; first nonzero duty appears one frame (PERIOD+1 cycles) after RUN entry.
- Fault → `pwm_enable` low exactly 1 cycle after `fault` sampled high, regardless of frame position.
- Reset mid-operation: immediate return to reset values; no ramp.
- Simultaneous `fault` and accept: the command is not accepted (ready low), and FAULT wins.

## Structure
- `pwm_drive_pkg`: state enum and default constants (PERIOD, DUTY_MAX, RAMP_STEP, GAP_FRAMES).
- Sub-module `frame_timer`: period counter with run/clear input and one-cycle `frame_tick` output. It is shared with future multi-channel versions.

## Test plan
- Reset, then cmd (duty 20, dir 0): `pwm_enable` rises 1 cycle after accept. duty_fwd = 0, 5, 10, 15, 20 on successive 501-cycle frames; duty_rev stays 0.
- Running fwd at 20, cmd (10, dir 1): `busy`=1. duty_fwd = 15, 10, 5, 0, then 2 frames with both 0, then duty_rev = 5, 10. `cmd_ready` stays low until RUN resumes.
- cmd duty 1000 → cur_duty saturates at 480. cmd duty 0 → ramps to 0, then IDLE with `pwm_enable`=0 one cycle after the boundary.
- `fault` pulse mid-frame at duty 15: next cycle enable, duties and cur_duty all 0, and `fault_latched`=1. `fault_clr` while `fault` is high is ignored; a later clear → IDLE, ready high.
- cmd in RUN at frame cycle 499 with new target 7 from 20: the boundary step uses the new target, giving 15.
- `rst_n` asserted mid-RAMP_DOWN: all outputs are 0 asynchronously and the state is IDLE.
